// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding and constant helpers for the key debouncer
package key_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    DWX  = 3'd1,
    HOLD = 3'd2,
    LONG = 3'd3,
    UPX  = 3'd4
  } key_state_t;

  function automatic int clog2(input int v);
    int r;
    longint x;
    r = 0;
    x = 1;
    while (x < longint'(v)) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_chan.sv
// rtl/key_chan.sv - one key channel: synchroniser, edge detect, debounce/long/repeat FSM
module key_chan
  import key_pkg::*;
#(
  parameter int ACTIVE_LOW = 1,
  parameter int T_DEB      = 2_000_000,
  parameter int T_LONG     = 100_000_000,
  parameter int T_RPT      = 20_000_000,
  parameter int CNT_W      = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_rpt,
  output logic key_state
);

  localparam logic INV = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] TC_DEB  = CNT_W'(T_DEB - 1);
  localparam logic [CNT_W-1:0] TC_HOLD = CNT_W'(T_LONG - T_DEB - 1);
  localparam logic [CNT_W-1:0] TC_RPT  = CNT_W'(T_RPT - 1);

  logic sync1, sync2, sync_d;
  logic cur, prev, dn_edge, up_edge;
  key_state_t state;
  logic [CNT_W-1:0] cnt;

  // Synchroniser resets to the released level so a key held through reset reads as a new press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= INV;
      sync2  <= INV;
      sync_d <= INV;
    end else begin
      sync1  <= key;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  assign cur     = sync2 ^ INV;
  assign prev    = sync_d ^ INV;
  assign dn_edge = cur & ~prev;
  assign up_edge = ~cur & prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_rpt     <= 1'b0;
      key_state   <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_rpt     <= 1'b0;
      // Edges are tested before terminal counts so a coincident edge suppresses the pulse
      case (state)
        IDLE: begin
          cnt <= '0;
          if (dn_edge) state <= DWX;
        end
        DWX: begin
          if (up_edge) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == TC_DEB) begin
            state     <= HOLD;
            cnt       <= '0;
            key_press <= 1'b1;
            key_state <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (up_edge) begin
            state <= UPX;
            cnt   <= '0;
          end else if (cnt == TC_HOLD) begin
            state    <= LONG;
            cnt      <= '0;
            key_long <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        LONG: begin
          if (up_edge) begin
            state <= UPX;
            cnt   <= '0;
          end else if (cnt == TC_RPT) begin
            cnt     <= '0;
            key_rpt <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        UPX: begin
          if (dn_edge) begin
            state <= HOLD;
            cnt   <= '0;
          end else if (cnt == TC_DEB) begin
            state       <= IDLE;
            cnt         <= '0;
            key_release <= 1'b1;
            key_state   <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          key_state <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_multi.sv
// rtl/key_multi.sv - multi-channel key debouncer with long-press and auto-repeat
module key_multi
  import key_pkg::*;
#(
  parameter int KEY_N      = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int T_DEB      = 2_000_000,
  parameter int T_LONG     = 100_000_000,
  parameter int T_RPT      = 20_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_N-1:0] key,
  output logic [KEY_N-1:0] key_press,
  output logic [KEY_N-1:0] key_release,
  output logic [KEY_N-1:0] key_long,
  output logic [KEY_N-1:0] key_rpt,
  output logic [KEY_N-1:0] key_state
);

  localparam int CNT_W = clog2(((T_LONG > T_RPT) ? T_LONG : T_RPT) + 1);

  if (KEY_N < 1) begin : g_bad_key_n
    $error("key_multi: KEY_N must be >= 1");
  end
  if (T_DEB < 2) begin : g_bad_deb
    $error("key_multi: T_DEB must be >= 2");
  end
  if (T_LONG <= T_DEB) begin : g_bad_long
    $error("key_multi: T_LONG must be > T_DEB");
  end
  if (T_RPT < 2) begin : g_bad_rpt
    $error("key_multi: T_RPT must be >= 2");
  end

  for (genvar i = 0; i < KEY_N; i++) begin : g_chan
    key_chan #(
      .ACTIVE_LOW(ACTIVE_LOW),
      .T_DEB     (T_DEB),
      .T_LONG    (T_LONG),
      .T_RPT     (T_RPT),
      .CNT_W     (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .key        (key[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i]),
      .key_rpt    (key_rpt[i]),
      .key_state  (key_state[i])
    );
  end

endmodule

// File: tb/tb_key_multi.sv
// tb/tb_key_multi.sv - randomized and directed bench for key_multi against a timestamp model
module tb_key_multi;

  localparam int KEY_N  = 2;
  localparam int T_DEB  = 8;
  localparam int T_LONG = 40;
  localparam int T_RPT  = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [KEY_N-1:0] key = '1;
  logic [KEY_N-1:0] key_press, key_release, key_long, key_rpt, key_state;

  key_multi #(
    .KEY_N(KEY_N), .ACTIVE_LOW(1), .T_DEB(T_DEB), .T_LONG(T_LONG), .T_RPT(T_RPT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key(key),
    .key_press(key_press), .key_release(key_release), .key_long(key_long),
    .key_rpt(key_rpt), .key_state(key_state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef enum int {M_IDLE, M_DEB, M_HELD, M_LONG, M_REL} mode_e;
  mode_e            mode [KEY_N];
  int               since[KEY_N];
  logic [3:0]       hist [KEY_N];
  logic [KEY_N-1:0] e_press, e_release, e_long, e_rpt, e_state;

  int press_n[KEY_N], press_at[KEY_N], rel_n[KEY_N], rel_at[KEY_N];
  int long_n[KEY_N], long_at[KEY_N], rpt_n[KEY_N], rpt_first[KEY_N], rpt_last[KEY_N];
  int state_hi[KEY_N];

  task automatic model_reset();
    for (int c = 0; c < KEY_N; c++) begin
      mode[c]  = M_IDLE;
      since[c] = 0;
      hist[c]  = 4'b0000;
    end
    e_press = '0; e_release = '0; e_long = '0; e_rpt = '0; e_state = '0;
  endtask

  // Each phase ends after its duration has elapsed since the phase began; edges abort a phase
  task automatic model_step(input int n);
    e_press = '0; e_release = '0; e_long = '0; e_rpt = '0;
    for (int c = 0; c < KEY_N; c++) begin
      logic rise, fall;
      int   el;
      hist[c] = {hist[c][2:0], ~key[c]};
      rise = hist[c][2] & ~hist[c][3];
      fall = ~hist[c][2] & hist[c][3];
      el   = n - since[c];
      case (mode[c])
        M_IDLE: if (rise) begin mode[c] = M_DEB; since[c] = n; end
        M_DEB:
          if (fall) begin mode[c] = M_IDLE; since[c] = n; end
          else if (el == T_DEB) begin
            mode[c] = M_HELD; since[c] = n; e_press[c] = 1'b1; e_state[c] = 1'b1;
          end
        M_HELD:
          if (fall) begin mode[c] = M_REL; since[c] = n; end
          else if (el == T_LONG - T_DEB) begin
            mode[c] = M_LONG; since[c] = n; e_long[c] = 1'b1;
          end
        M_LONG:
          if (fall) begin mode[c] = M_REL; since[c] = n; end
          else if (el == T_RPT) begin since[c] = n; e_rpt[c] = 1'b1; end
        default:
          if (rise) begin mode[c] = M_HELD; since[c] = n; end
          else if (el == T_DEB) begin
            mode[c] = M_IDLE; since[c] = n; e_release[c] = 1'b1; e_state[c] = 1'b0;
          end
      endcase
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        cyc = cyc + 1;
        model_step(cyc);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      vectors++;
      if ({key_press, key_release, key_long, key_rpt, key_state} !==
          {e_press, e_release, e_long, e_rpt, e_state}) begin
        miscompares++;
        $display("FAIL cycle_check cyc=%0d got p=%b r=%b l=%b t=%b s=%b exp p=%b r=%b l=%b t=%b s=%b",
                 cyc, key_press, key_release, key_long, key_rpt, key_state,
                 e_press, e_release, e_long, e_rpt, e_state);
      end
      for (int c = 0; c < KEY_N; c++) begin
        if (e_press[c])   begin press_n[c]++; press_at[c] = cyc; end
        if (e_release[c]) begin rel_n[c]++;   rel_at[c]   = cyc; end
        if (e_long[c])    begin long_n[c]++;  long_at[c]  = cyc; end
        if (e_rpt[c]) begin
          if (rpt_n[c] == 0) rpt_first[c] = cyc;
          rpt_last[c] = cyc;
          rpt_n[c]++;
        end
        if (e_state[c]) state_hi[c]++;
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic clear_rec();
    for (int c = 0; c < KEY_N; c++) begin
      press_n[c] = 0; press_at[c] = -1; rel_n[c] = 0; rel_at[c] = -1;
      long_n[c] = 0; long_at[c] = -1; rpt_n[c] = 0; rpt_first[c] = -1; rpt_last[c] = -1;
      state_hi[c] = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int t, ge;
  int dur[KEY_N];

  initial begin
    clear_rec();
    idle(3);
    chk("reset_state", int'(key_state), 0);
    rst_n = 1'b1;
    idle(5);

    // 1: clean 20-cycle press
    clear_rec(); t = cyc;
    key[0] = 1'b0; idle(20); key[0] = 1'b1; idle(40);
    chk("t1_press_n", press_n[0], 1);
    chk("t1_press_lat", press_at[0] - t, 11);
    chk("t1_release_lat", rel_at[0] - t, 31);
    chk("t1_state_cycles", state_hi[0], 20);
    chk("t1_no_long", long_n[0], 0);

    // 2: 5-cycle bounce rejected
    clear_rec();
    key[0] = 1'b0; idle(5); key[0] = 1'b1; idle(30);
    chk("t2_press_n", press_n[0], 0);
    chk("t2_release_n", rel_n[0], 0);
    chk("t2_state_cycles", state_hi[0], 0);

    // 3: 75-cycle hold with long and repeats
    clear_rec(); t = cyc;
    key[0] = 1'b0; idle(75); key[0] = 1'b1; idle(40);
    chk("t3_press_lat", press_at[0] - t, 11);
    chk("t3_long_lat", long_at[0] - t, 43);
    chk("t3_rpt_n", rpt_n[0], 3);
    chk("t3_rpt_first", rpt_first[0] - t, 53);
    chk("t3_rpt_last", rpt_last[0] - t, 73);
    chk("t3_release_lat", rel_at[0] - t, 86);

    // 4: release glitch during HOLD restarts the long timer
    clear_rec(); t = cyc;
    key[0] = 1'b0; idle(15);
    key[0] = 1'b1; idle(3);
    key[0] = 1'b0; ge = cyc; idle(60);
    chk("t4_no_release", rel_n[0], 0);
    chk("t4_state_held", int'(key_state[0]), 1);
    chk("t4_long_n", long_n[0], 1);
    // 32 cycles after HOLD re-entry, which trails the raw edge by 3 synchroniser cycles
    chk("t4_long_after_glitch", long_at[0] - ge, 35);
    key[0] = 1'b1; idle(40);

    // 5: two channels offset by 2 cycles
    clear_rec(); t = cyc;
    key[0] = 1'b0; idle(2); key[1] = 1'b0; idle(18);
    key[0] = 1'b1; idle(2); key[1] = 1'b1; idle(40);
    chk("t5_press_lat0", press_at[0] - t, 11);
    chk("t5_press_offset", press_at[1] - press_at[0], 2);
    chk("t5_release_offset", rel_at[1] - rel_at[0], 2);
    chk("t5_press_n1", press_n[1], 1);
    chk("t5_long_n1", long_n[1], 0);

    // 6: async reset during LONG with the key still held
    clear_rec();
    key[0] = 1'b0; idle(50);
    chk("t6_state_before", int'(key_state[0]), 1);
    @(posedge clk); #2 rst_n = 1'b0; #1;
    chk("t6_async_outputs", int'({key_press, key_release, key_long, key_rpt, key_state}), 0);
    idle(3);
    rst_n = 1'b1; t = cyc; clear_rec();
    idle(20);
    chk("t6_press_after_reset", press_at[0] - t, 11);
    chk("t6_no_trailing_release", rel_n[0], 0);
    key[0] = 1'b1; idle(40);

    // Randomized bounces, long holds and occasional mid-cycle resets
    for (int c = 0; c < KEY_N; c++) dur[c] = $urandom_range(0, 20);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      for (int c = 0; c < KEY_N; c++) begin
        if (dur[c] == 0) begin
          key[c] = ~key[c];
          dur[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 80);
        end else begin
          dur[c] = dur[c] - 1;
        end
      end
      if ($urandom_range(0, 999) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    key = '1;
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
